// File: rtl/ambilight_pkg.sv
// Shared constants and types for the colour-buffer s2 port arbiter.
package ambilight_pkg;

  localparam int AW    = 12;
  localparam int DW    = 32;
  localparam int BW    = DW / 8;
  localparam int DEPTH = 4000;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  typedef struct packed {
    logic valid;
    logic owner;
    logic is_read;
    logic err;
  } resp_t;

endpackage

// File: rtl/ambilight_rr_arb2.sv
// Two-way round-robin arbiter; the pointer names the requester that wins a tie.
module ambilight_rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic rr_ptr;

  always_comb begin
    gnt = 2'b00;
    if (advance) begin
      if (&req) gnt = rr_ptr ? 2'b10 : 2'b01;
      else      gnt = req;
    end
  end

  // after a grant to N the other requester gets the next tie
  always_ff @(posedge clk) begin
    if (reset)     rr_ptr <= 1'b0;
    else if (|gnt) rr_ptr <= gnt[0];
  end

endmodule

// File: rtl/ambilight_mem_arbiter.sv
// Shares colour-buffer port s2 between the zone accumulator (r0) and LED driver (r1).
// state | meaning:  IDLE = arbitrate requesters,  CLEAR = sweep zeros over 0..DEPTH-1
module ambilight_mem_arbiter
  import ambilight_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          clear_start,
  output logic          clear_busy,
  input  logic          r0_req,
  input  logic          r0_write,
  input  logic [AW-1:0] r0_addr,
  input  logic [DW-1:0] r0_wdata,
  input  logic [BW-1:0] r0_be,
  output logic          r0_gnt,
  output logic          r0_rvalid,
  output logic [DW-1:0] r0_rdata,
  output logic          r0_err,
  input  logic          r1_req,
  input  logic          r1_write,
  input  logic [AW-1:0] r1_addr,
  input  logic [DW-1:0] r1_wdata,
  input  logic [BW-1:0] r1_be,
  output logic          r1_gnt,
  output logic          r1_rvalid,
  output logic [DW-1:0] r1_rdata,
  output logic          r1_err,
  output logic [AW-1:0] mem_address,
  output logic [BW-1:0] mem_byteenable,
  output logic          mem_chipselect,
  output logic          mem_write,
  output logic [DW-1:0] mem_writedata,
  output logic          mem_clken,
  input  logic [DW-1:0] mem_readdata
);

  state_t        state, state_next;
  logic [AW-1:0] clr_cnt;
  resp_t         resp, resp_next;
  logic [1:0]    gnt;
  logic          advance;
  logic          win;
  logic          win_write;
  logic          win_oor;
  logic [AW-1:0] win_addr;
  logic [DW-1:0] win_wdata;
  logic [BW-1:0] win_be;

  // no grant on the cycle that launches a clear
  assign advance = (state == IDLE) && !clear_start && !reset;

  ambilight_rr_arb2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     ({r1_req, r0_req}),
    .advance (advance),
    .gnt     (gnt)
  );

  assign r0_gnt    = gnt[0];
  assign r1_gnt    = gnt[1];
  assign win       = gnt[1];
  assign win_addr  = win ? r1_addr  : r0_addr;
  assign win_write = win ? r1_write : r0_write;
  assign win_wdata = win ? r1_wdata : r0_wdata;
  assign win_be    = win ? r1_be    : r0_be;
  assign win_oor   = (win_addr >= AW'(DEPTH));
  assign mem_clken = 1'b1;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (clear_start) state_next = CLEAR;
      CLEAR: if (clr_cnt == AW'(DEPTH - 1)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)                  clr_cnt <= '0;
    else if (state != CLEAR)    clr_cnt <= '0;
    else if (clr_cnt == AW'(DEPTH - 1)) clr_cnt <= '0;
    else                        clr_cnt <= clr_cnt + 1'b1;
  end

  // outputs are held quiet during reset so an aborted sweep writes nothing more
  always_comb begin
    clear_busy     = 1'b0;
    mem_chipselect = 1'b0;
    mem_write      = 1'b0;
    mem_address    = '0;
    mem_writedata  = '0;
    mem_byteenable = '0;
    if (!reset) begin
      if (state == CLEAR) begin
        clear_busy     = 1'b1;
        mem_chipselect = 1'b1;
        mem_write      = 1'b1;
        mem_address    = clr_cnt;
        mem_byteenable = '1;
      end else if (|gnt) begin
        mem_chipselect = !win_oor;
        mem_write      = win_write && !win_oor;
        mem_address    = win_addr;
        mem_writedata  = win_wdata;
        mem_byteenable = win_be;
      end
    end
  end

  always_comb begin
    resp_next.valid   = |gnt;
    resp_next.owner   = win;
    resp_next.is_read = !win_write;
    resp_next.err     = win_oor;
  end

  always_ff @(posedge clk) begin
    if (reset) resp <= '0;
    else       resp <= resp_next;
  end

  assign r0_rvalid = resp.valid && !resp.owner && resp.is_read;
  assign r1_rvalid = resp.valid &&  resp.owner && resp.is_read;
  assign r0_err    = resp.valid && !resp.owner && resp.err;
  assign r1_err    = resp.valid &&  resp.owner && resp.err;
  assign r0_rdata  = (r0_rvalid && !resp.err) ? mem_readdata : '0;
  assign r1_rdata  = (r1_rvalid && !resp.err) ? mem_readdata : '0;

endmodule
